// File: rtl/pico_mem_hs.sv
// -----------------------------------------------------------------------------
// pico_mem_hs
//   Single-port data memory for the PicoComputer CPU with a valid/ready request
//   channel, a valid/ready response channel, programmable wait states and
//   out-of-range error reporting. One transaction is outstanding at a time.
//
// Parameters
//   DATA_W       data word width in bits
//   ADDR_W       address width in bits
//   DEPTH        implemented words (1..2**ADDR_W); addr >= DEPTH is an error
//   WAIT_CYCLES  extra cycles between accept and commit (0..15)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (IDLE)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  response present (RESP)
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  read data, or the written word for a write
//   rsp_err    out  address out of range, qualified by rsp_valid
//   busy       out  high whenever not IDLE
// -----------------------------------------------------------------------------
module pico_mem_hs #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                accept;
    logic                commit;
    logic                in_range;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign in_range = (32'(addr_q) < DEPTH);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // The counter is loaded with WAIT_CYCLES and the commit happens on the
    // edge where it reads zero, so the accepted request always spends
    // WAIT_CYCLES+1 edges in WAIT. This gives a uniform latency of
    // WAIT_CYCLES+1 from accept to rsp_valid, including WAIT_CYCLES == 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= 4'(WAIT_CYCLES);
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (commit) begin
                if (!in_range) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (we_q) begin
                    rdata_q <= wdata_q;
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= mem[addr_q];
                    err_q   <= 1'b0;
                end
            end else if (state_q == S_RESP && rsp_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; it maps onto plain RAM and a reset
    // during WAIT simply never reaches the commit that would write it.
    always_ff @(posedge clk) begin
        if (commit && we_q && in_range) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pico_mem_hs.sv
// -----------------------------------------------------------------------------
// tb_pico_mem_hs
//   Directed bench for pico_mem_hs. Three instances share clk/rst_n:
//     0: DEPTH=64, WAIT_CYCLES=2   1: DEPTH=48, WAIT_CYCLES=2
//     2: DEPTH=64, WAIT_CYCLES=0
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pico_mem_hs;

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [5:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pico_mem_hs #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    pico_mem_hs #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    pico_mem_hs #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .WAIT_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until accepted; returns at the falling
    // edge right after the accepting rising edge, request withdrawn.
    task automatic issue(input int d, input logic we, input logic [5:0] addr,
                         input logic [15:0] wdata);
        int n;
        @(negedge clk);
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    // Count rising edges after the accept until rsp_valid, then handshake.
    task automatic finish_rsp(input int d, output logic [15:0] rdata,
                              output logic err, output int lat);
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic txn(input int d, input logic we, input logic [5:0] addr,
                       input logic [15:0] wdata, output logic [15:0] rdata,
                       output logic err, output int lat);
        issue(d, we, addr, wdata);
        finish_rsp(d, rdata, err, lat);
    endtask

    logic [15:0] model [64];
    int          order [64];
    logic [15:0] rd;
    logic        er;
    int          lat;

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
        end
        rst_n = 1'b1;

        // 1. asynchronous reset mid-cycle, effective before any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst busy",      32'(busy[0]),      32'd0);
        check("rst req_ready", 32'(req_ready[0]), 32'd1);
        check("rst rsp_err",   32'(rsp_err[0]),   32'd0);
        check("rst rsp_rdata", 32'(rsp_rdata[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst req_ready", 32'(req_ready[0]), 32'd1);

        // 2. write then read addr 5
        txn(0, 1'b1, 6'd5, 16'hBEEF, rd, er, lat);
        check("wr5 latency", 32'(lat), 32'd3);
        check("wr5 rdata",   32'(rd),  32'hBEEF);
        check("wr5 err",     32'(er),  32'd0);
        txn(0, 1'b0, 6'd5, 16'h0000, rd, er, lat);
        check("rd5 rdata",   32'(rd),  32'hBEEF);
        check("rd5 err",     32'(er),  32'd0);

        // 3. fill all words, read back in shuffled order
        for (int i = 0; i < 64; i++) begin
            model[i] = 16'($urandom);
            txn(0, 1'b1, 6'(i), model[i], rd, er, lat);
            check("fill latency", 32'(lat), 32'd3);
        end
        for (int i = 0; i < 64; i++) order[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 64; i++) begin
            txn(0, 1'b0, 6'(order[i]), 16'h0000, rd, er, lat);
            check("scoreboard rdata", 32'(rd),  32'(model[order[i]]));
            check("scoreboard lat",   32'(lat), 32'd3);
        end

        // 4. DEPTH=48 range errors
        txn(1, 1'b1, 6'd50, 16'h1234, rd, er, lat);
        check("oor wr err",   32'(er), 32'd1);
        check("oor wr rdata", 32'(rd), 32'h0);
        txn(1, 1'b0, 6'd50, 16'h0000, rd, er, lat);
        check("oor rd err",   32'(er), 32'd1);
        check("oor rd rdata", 32'(rd), 32'h0);
        check("err cleared",  32'(rsp_err[1]), 32'd0);
        txn(1, 1'b1, 6'd47, 16'h4747, rd, er, lat);
        check("a47 wr err",   32'(er), 32'd0);
        txn(1, 1'b0, 6'd47, 16'h0000, rd, er, lat);
        check("a47 rd rdata", 32'(rd), 32'h4747);
        check("a47 rd err",   32'(er), 32'd0);

        // 5. response back-pressure; a competing request must be ignored
        txn(0, 1'b1, 6'd10, 16'h00AA, rd, er, lat);
        issue(0, 1'b0, 6'd10, 16'h0000);
        repeat (3) @(negedge clk);
        check("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
        req_we[0]    = 1'b1;
        req_addr[0]  = 6'd10;
        req_wdata[0] = 16'hFFFF;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold valid", 32'(rsp_valid[0]), 32'd1);
            check("bp hold rdata", 32'(rsp_rdata[0]), 32'h00AA);
            check("bp hold err",   32'(rsp_err[0]),   32'd0);
            check("bp req_ready",  32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp released", 32'(rsp_valid[0]), 32'd0);
        txn(0, 1'b0, 6'd10, 16'h0000, rd, er, lat);
        check("bp no write", 32'(rd), 32'h00AA);

        // 6. reset during WAIT discards the pending write
        txn(0, 1'b1, 6'd3, 16'h5555, rd, er, lat);
        issue(0, 1'b1, 6'd3, 16'hAAAA);
        check("in wait busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("wait rst busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 6'd3, 16'h0000, rd, er, lat);
        check("rst discard rdata", 32'(rd), 32'h5555);

        // 6b. zero wait states
        txn(2, 1'b1, 6'd3, 16'h5555, rd, er, lat);
        check("w0 wr latency", 32'(lat), 32'd1);
        check("w0 wr rdata",   32'(rd),  32'h5555);
        txn(2, 1'b0, 6'd3, 16'h0000, rd, er, lat);
        check("w0 rd latency", 32'(lat), 32'd1);
        check("w0 rd rdata",   32'(rd),  32'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
